// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ producers.
// One idle arbitration cycle per grant; a grant lasts until last or BURST beats.
module fifo_wr_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int BURST = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_data_in,
  input  logic                  fifo_wr_full,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int BCW = 4;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);
  localparam logic [IDW-1:0] PTR_RST   = IDW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   grant_reg;
  logic [BCW-1:0]   beat_cnt_reg;
  logic [IDW-1:0]   arb_id_next;
  logic             arb_found_next;
  logic             in_grant;
  logic             release_beat;
  logic [WIDTH-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign slice[gi]     = req_data[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = in_grant & (grant_reg == IDW'(gi)) & ~fifo_wr_full;
    end
  endgenerate

  // Search starts just after the last grant holder, wrapping modulo NREQ.
  always_comb begin
    int idx;
    arb_found_next = 1'b0;
    arb_id_next    = '0;
    idx            = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!arb_found_next && req_valid[IDW'(idx)]) begin
        arb_found_next = 1'b1;
        arb_id_next    = IDW'(idx);
      end
    end
  end

  assign in_grant     = (state_reg == GRANT);
  assign fifo_wr_en   = in_grant & req_valid[grant_reg] & ~fifo_wr_full;
  assign fifo_data_in = in_grant ? slice[grant_reg] : '0;
  assign release_beat = req_last[grant_reg] | (beat_cnt_reg == LAST_BEAT);
  assign grant_id     = grant_reg;
  assign busy         = in_grant;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= PTR_RST;
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_found_next) begin
            grant_reg    <= arb_id_next;
            beat_cnt_reg <= '0;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          // Stalled or empty cycles leave the grant and beat count untouched.
          if (fifo_wr_en) begin
            if (release_beat) begin
              rr_ptr_reg   <= grant_reg;
              beat_cnt_reg <= '0;
              state_reg    <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
